// File: rtl/sprite_pkg.sv
// Shared sprite-sheet geometry, header sync code and writer states.
// Imported by both the Rojobot icon renderer and the sprite frame writer.
package sprite_pkg;

   localparam int SPRITE_COLS    = 34;
   localparam int SPRITE_ROWS    = 34;
   localparam int FRAME_COLS     = 3;
   localparam int FRAME_ROWS     = 8;
   localparam int MEM_COLS       = FRAME_COLS * SPRITE_COLS;
   localparam int FRAME_ROW_SIZE = SPRITE_ROWS * MEM_COLS;

   localparam logic [2:0] HDR_SYNC = 3'b101;

   typedef enum logic [2:0] {IDLE, PIX_HI, PIX_LO, WRITE, DONE, CSUM} state_t;

   // Word address of the top-left pixel of sheet slot (row, col).
   function automatic int frame_base(input logic [2:0] row, input logic [1:0] col);
      return int'(row) * FRAME_ROW_SIZE + int'(col) * SPRITE_COLS;
   endfunction

endpackage

// File: rtl/sprite_addr_gen.sv
// Pixel address generator: x/y counters plus a row_base accumulator, so the
// per-pixel address is row_base + x with no multiplier in the pixel path.
module sprite_addr_gen
   import sprite_pkg::*;
#(
   parameter int ADDR_W = 15
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              load,
   input  logic [ADDR_W-1:0] base,
   input  logic              step,
   output logic [ADDR_W-1:0] addr,
   output logic              last
);

   localparam int XW = $clog2(SPRITE_COLS);
   localparam int YW = $clog2(SPRITE_ROWS);

   logic [XW-1:0]     x;
   logic [YW-1:0]     y;
   logic [ADDR_W-1:0] row_base;
   logic              x_wrap;

   assign x_wrap = (x == XW'(SPRITE_COLS - 1));
   assign last   = x_wrap && (y == YW'(SPRITE_ROWS - 1));
   assign addr   = row_base + ADDR_W'(x);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         x        <= '0;
         y        <= '0;
         row_base <= '0;
      end else if (load) begin
         x        <= '0;
         y        <= '0;
         row_base <= base;
      end else if (step) begin
         if (x_wrap) begin
            x        <= '0;
            y        <= y + 1'b1;
            row_base <= row_base + ADDR_W'(MEM_COLS);
         end else begin
            x <= x + 1'b1;
         end
      end
   end

endmodule

// File: rtl/sprite_frame_writer.sv
// Byte-stream writer that unpacks 12-bit pixels into one sprite-sheet slot.
// Define SPRITE_WRITER_CHECKSUM_EN to require a trailing XOR checksum byte.
module sprite_frame_writer
   import sprite_pkg::*;
#(
   parameter int ADDR_W = 15
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [7:0]        s_data,
   input  logic              s_valid,
   output logic              s_ready,
   input  logic              abort,
   output logic              wr_en,
   output logic [ADDR_W-1:0] wr_addr,
   output logic [11:0]       wr_data,
   output logic              busy,
   output logic              done,
   output logic              err
);

   state_t            state, state_nx;
   logic              hdr_ok;
   logic [ADDR_W-1:0] hdr_base;
   logic              gen_load, gen_step, gen_last;
   logic [3:0]        pix_hi;
`ifdef SPRITE_WRITER_CHECKSUM_EN
   logic [7:0]        csum;
`endif

   assign hdr_ok   = (s_data[2:0] == HDR_SYNC) && (int'(s_data[4:3]) < FRAME_COLS);
   assign hdr_base = ADDR_W'(frame_base(s_data[7:5], s_data[4:3]));
   assign gen_load = (state == IDLE) && s_valid && hdr_ok && !abort;
   assign gen_step = (state == WRITE) && !abort;

   sprite_addr_gen #(.ADDR_W(ADDR_W)) u_addr_gen (
      .clk   (clk),
      .reset (reset),
      .load  (gen_load),
      .base  (hdr_base),
      .step  (gen_step),
      .addr  (wr_addr),
      .last  (gen_last)
   );

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) state <= IDLE;
      else        state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      s_ready  = 1'b0;
      wr_en    = 1'b0;
      busy     = 1'b1;
      done     = 1'b0;
      case (state)
         IDLE: begin
            s_ready = 1'b1;
            busy    = 1'b0;
            if (s_valid && hdr_ok) state_nx = PIX_HI;
         end
         PIX_HI: begin
            s_ready = 1'b1;
            if (s_valid) state_nx = PIX_LO;
         end
         PIX_LO: begin
            s_ready = 1'b1;
            if (s_valid) state_nx = WRITE;
         end
         WRITE: begin
            wr_en = 1'b1;
`ifdef SPRITE_WRITER_CHECKSUM_EN
            state_nx = gen_last ? CSUM : PIX_HI;
`else
            state_nx = gen_last ? DONE : PIX_HI;
`endif
         end
`ifdef SPRITE_WRITER_CHECKSUM_EN
         CSUM: begin
            s_ready = 1'b1;
            if (s_valid) state_nx = DONE;
         end
`endif
         DONE: begin
            done     = 1'b1;
            state_nx = IDLE;
         end
         default: state_nx = IDLE;
      endcase
      // Abort wins over any byte presented in the same cycle.
      if (abort) state_nx = IDLE;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         err     <= 1'b0;
         pix_hi  <= '0;
         wr_data <= '0;
`ifdef SPRITE_WRITER_CHECKSUM_EN
         csum    <= '0;
`endif
      end else if (!abort && s_valid) begin
         case (state)
            IDLE: begin
               err <= !hdr_ok;
`ifdef SPRITE_WRITER_CHECKSUM_EN
               if (hdr_ok) csum <= '0;
`endif
            end
            PIX_HI: begin
               pix_hi <= s_data[3:0];
`ifdef SPRITE_WRITER_CHECKSUM_EN
               csum   <= csum ^ s_data;
`endif
            end
            PIX_LO: begin
               wr_data <= {pix_hi, s_data};
`ifdef SPRITE_WRITER_CHECKSUM_EN
               csum    <= csum ^ s_data;
`endif
            end
`ifdef SPRITE_WRITER_CHECKSUM_EN
            CSUM: if (s_data != csum) err <= 1'b1;
`endif
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_sprite_frame_writer.sv
// Directed bench for sprite_frame_writer: full frames, stalls, bad headers,
// abort, asynchronous reset and (when enabled) the checksum byte.
`timescale 1ns/100ps
module tb_sprite_frame_writer;

   localparam int ADDR_W = 15;

   logic              clk = 1'b0;
   logic              reset;
   logic [7:0]        s_data;
   logic              s_valid;
   logic              s_ready;
   logic              abort;
   logic              wr_en;
   logic [ADDR_W-1:0] wr_addr;
   logic [11:0]       wr_data;
   logic              busy;
   logic              done;
   logic              err;

   int tests = 0;
   int fails = 0;

   // write monitor state
   int   exp_base;
   int   wcnt, dcnt, mon_bad;
   int   first_addr, first_data, second_addr, second_data, last_addr;
   int   cyc, last_wr_cyc, done_cyc;
   logic prev_wr;
   logic [7:0] csum;

   sprite_frame_writer #(.ADDR_W(ADDR_W)) dut (
      .clk     (clk),
      .reset   (reset),
      .s_data  (s_data),
      .s_valid (s_valid),
      .s_ready (s_ready),
      .abort   (abort),
      .wr_en   (wr_en),
      .wr_addr (wr_addr),
      .wr_data (wr_data),
      .busy    (busy),
      .done    (done),
      .err     (err)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc++;

   always @(negedge clk) begin
      if (wr_en) begin
         int ea;
         ea = exp_base + (wcnt / 34) * 102 + (wcnt % 34);
         if (wcnt == 0) begin first_addr = 32'(wr_addr); first_data = 32'(wr_data); end
         if (wcnt == 1) begin second_addr = 32'(wr_addr); second_data = 32'(wr_data); end
         if (32'(wr_addr) !== ea || wr_data !== 12'(wcnt) || s_ready !== 1'b0 || prev_wr === 1'b1)
            mon_bad++;
         last_addr   = 32'(wr_addr);
         last_wr_cyc = cyc;
         wcnt++;
      end
      if (done) begin
         dcnt++;
         done_cyc = cyc;
      end
      prev_wr = wr_en;
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic clear_mon(input int base);
      exp_base = base;
      wcnt = 0; dcnt = 0; mon_bad = 0;
      first_addr = -1; first_data = -1; second_addr = -1; second_data = -1;
      last_addr = -1; last_wr_cyc = -1; done_cyc = -1;
      csum = 8'h00;
   endtask

   task automatic idle();
      @(posedge clk); #1;
   endtask

   task automatic send(input logic [7:0] b);
      int t;
      t = 0;
      s_data  = b;
      s_valid = 1'b1;
      while (s_ready !== 1'b1 && t < 100) begin
         @(posedge clk); #1;
         t++;
      end
      if (t >= 100) check("s_ready_timeout", 32'(t), 32'd0);
      @(posedge clk); #1;
      s_valid = 1'b0;
   endtask

   task automatic send_pixels(input int npix, input bit gap);
      logic [7:0] hi, lo;
      for (int n = 0; n < npix; n++) begin
         hi = {4'hA, 4'(n >> 8)};
         lo = 8'(n);
         send(hi);
         if (gap) idle();
         send(lo);
         if (gap) idle();
         csum = csum ^ hi ^ lo;
      end
   endtask

   task automatic finish_frame(input bit corrupt);
`ifdef SPRITE_WRITER_CHECKSUM_EN
      send(csum ^ {7'b0, corrupt});
`else
      if (corrupt) idle();
`endif
      repeat (3) idle();
   endtask

   task automatic check_full_frame(input string tag);
      int done_lat;
`ifdef SPRITE_WRITER_CHECKSUM_EN
      done_lat = 2;
`else
      done_lat = 1;
`endif
      check({tag, "_wr_count"},   32'(wcnt), 32'd1156);
      check({tag, "_first_addr"}, 32'(first_addr), 32'd10438);
      check({tag, "_first_data"}, 32'(first_data), 32'h000);
      check({tag, "_second_addr"}, 32'(second_addr), 32'd10439);
      check({tag, "_second_data"}, 32'(second_data), 32'h001);
      check({tag, "_last_addr"},  32'(last_addr), 32'd13837);
      check({tag, "_pixel_stream"}, 32'(mon_bad), 32'd0);
      check({tag, "_done_count"}, 32'(dcnt), 32'd1);
      check({tag, "_done_latency"}, 32'(done_cyc - last_wr_cyc), 32'(done_lat));
      check({tag, "_busy_after"}, 32'(busy), 32'd0);
      check({tag, "_err_after"},  32'(err), 32'd0);
      check({tag, "_ready_after"}, 32'(s_ready), 32'd1);
   endtask

   initial begin
      reset = 1'b0; s_valid = 1'b0; s_data = 8'h00; abort = 1'b0; prev_wr = 1'b0;
      cyc = 0;
      clear_mon(0);
      #22;
      check("rst_s_ready", 32'(s_ready), 32'd1);
      check("rst_wr_en",   32'(wr_en),   32'd0);
      check("rst_wr_addr", 32'(wr_addr), 32'd0);
      check("rst_wr_data", 32'(wr_data), 32'd0);
      check("rst_busy",    32'(busy),    32'd0);
      check("rst_done",    32'(done),    32'd0);
      check("rst_err",     32'(err),     32'd0);
      reset = 1'b1;
      idle();

      // Full frame into slot (row 3, col 1), back-to-back bytes.
      clear_mon(10438);
      send(8'b011_01_101);
      check("t1_busy_hdr", 32'(busy), 32'd1);
      send_pixels(1156, 1'b0);
      finish_frame(1'b0);
      check_full_frame("t1");

      // Bad headers set err without starting a frame; a good header clears it.
      clear_mon(10438);
      send(8'h1D);
      check("bad_col_err",   32'(err),  32'd1);
      check("bad_col_busy",  32'(busy), 32'd0);
      send(8'h6C);
      check("bad_sync_err",  32'(err),  32'd1);
      check("bad_sync_busy", 32'(busy), 32'd0);
      send(8'h6D);
      check("good_hdr_err",  32'(err),  32'd0);
      check("good_hdr_busy", 32'(busy), 32'd1);
      abort = 1'b1; idle(); abort = 1'b0;
      check("bad_hdr_no_wr", 32'(wcnt), 32'd0);

      // Same frame with s_valid gaps between every byte.
      clear_mon(10438);
      send(8'h6D);
      send_pixels(1156, 1'b1);
      finish_frame(1'b0);
      check_full_frame("t3");

      // Abort after 500 pixels into slot (0,0), with a byte offered alongside abort.
      clear_mon(0);
      send(8'h05);
      send_pixels(500, 1'b0);
      idle();
      s_data = 8'h55; s_valid = 1'b1; abort = 1'b1;
      idle();
      s_valid = 1'b0; abort = 1'b0;
      check("abort_busy",  32'(busy),    32'd0);
      check("abort_ready", 32'(s_ready), 32'd1);
      repeat (5) idle();
      check("abort_wr_count",  32'(wcnt),      32'd500);
      check("abort_last_addr", 32'(last_addr), 32'd1451);
      check("abort_no_done",   32'(dcnt),      32'd0);
      check("abort_stream",    32'(mon_bad),   32'd0);
      s_data = 8'h05; s_valid = 1'b1; abort = 1'b1;
      idle();
      s_valid = 1'b0; abort = 1'b0;
      check("abort_hdr_dropped", 32'(busy), 32'd0);
      clear_mon(0);
      send(8'h05);
      send_pixels(2, 1'b0);
      repeat (2) idle();
      check("restart_addr0", 32'(first_addr),  32'd0);
      check("restart_addr1", 32'(second_addr), 32'd1);
      check("restart_data1", 32'(second_data), 32'h001);
      abort = 1'b1; idle(); abort = 1'b0;

      // Asynchronous reset while WRITE is on the bus.
      clear_mon(10438);
      send(8'h6D);
      send_pixels(3, 1'b0);
      check("pre_rst_wr_en",   32'(wr_en),   32'd1);
      check("pre_rst_wr_addr", 32'(wr_addr), 32'd10440);
      check("pre_rst_wr_data", 32'(wr_data), 32'h002);
      #2 reset = 1'b0;
      #0.5;
      check("arst_wr_en",   32'(wr_en),   32'd0);
      check("arst_wr_addr", 32'(wr_addr), 32'd0);
      check("arst_wr_data", 32'(wr_data), 32'd0);
      check("arst_busy",    32'(busy),    32'd0);
      check("arst_s_ready", 32'(s_ready), 32'd1);
      check("arst_done",    32'(done),    32'd0);
      check("arst_err",     32'(err),     32'd0);
      #0.5 reset = 1'b1;
      idle();
      check("post_rst_busy", 32'(busy), 32'd0);

`ifdef SPRITE_WRITER_CHECKSUM_EN
      // Corrupted checksum byte: done still pulses, err is raised.
      clear_mon(10438);
      send(8'h6D);
      send_pixels(1156, 1'b0);
      finish_frame(1'b1);
      check("csum_bad_done", 32'(dcnt), 32'd1);
      check("csum_bad_err",  32'(err),  32'd1);
      check("csum_bad_wr",   32'(wcnt), 32'd1156);
`endif

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
